// File: rtl/sm_seq_multiplier.sv
// Sequential sign-magnitude multiplier, shift-add datapath, one magnitude bit per clock.
// Latency: done_o pulses in the cycle after edge E0+(WIDTH-1), where E0 samples start_i.
// No backpressure: start_i is only sampled in IDLE; requests in RUN/DONE are dropped.
module sm_seq_multiplier #(
  parameter int WIDTH = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   number1_i,
  input  logic [WIDTH-1:0]   number2_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-2:0] mult_o
);

  localparam int MW = WIDTH - 1;        // magnitude width
  localparam int AW = 2 * WIDTH - 2;    // accumulator width
  localparam int CW = $clog2(WIDTH);    // counter width, holds 0..WIDTH-1
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] mcand_q, mcand_d;     // multiplicand, pre-shifted by the counter
  logic [MW-1:0] mplier_q, mplier_d;   // multiplier, LSB is the bit under test
  logic          sign_q, sign_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   mult_q, mult_d;

  logic          last_bit;
  logic [AW-1:0] acc_sum;

  assign last_bit = (cnt_q == CNT_LAST);
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: DONE always falls back to IDLE so a held start_i costs one idle cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decodes of registered state/result only
  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    mult_o = mult_q;
  end

  // Datapath next-state: capture in IDLE, shift-add in RUN, publish result on the last RUN edge
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mult_d   = mult_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = {{MW{1'b0}}, number1_i[MW-1:0]};
          mplier_d = number2_i[MW-1:0];
          sign_d   = number1_i[WIDTH-1] ^ number2_i[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        // A zero magnitude always reports a positive sign
        if (last_bit) mult_d = {sign_q & (|acc_sum), acc_sum};
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears the held result so an aborted run leaves zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mult_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mult_q   <= mult_d;
    end
  end

endmodule
